// File: rtl/i2c_slave_byte_ctrl.sv
// I2C slave byte sequencer: address match, ACK generation and byte
// shifting between i2c_slave_bit_ctrl and the peripheral register side.
module i2c_slave_byte_ctrl #(
  parameter bit GENCALL_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [6:0] slave_addr,
  output logic [3:0] bit_cmd,
  output logic       bit_din,
  input  logic       bit_ack,
  input  logic       bit_dout,
  input  logic       bit_sta,
  input  logic       bit_stop,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       rd_mode,
  output logic       addr_hit,
  output logic       nack_rcvd,
  output logic       xfer_done
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } state_e;

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [6:0] sh_q;
  logic [7:0] txsh_q;
  logic       skip_q;
  logic       stop_q;
  logic       first_q;
  logic [3:0] cmd_q;
  logic       din_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rx_first_q;
  logic       tx_req_q;
  logic       rd_q;
  logic       hit_q;
  logic       nack_q;
  logic       done_q;

  logic [7:0] byte_d;
  logic       hit_d;
  logic       stop_edge_d;

  assign byte_d      = {sh_q, bit_dout};
  assign hit_d       = (byte_d[7:1] == slave_addr)
                     | (GENCALL_EN && (byte_d == 8'h00));
  assign stop_edge_d = bit_stop & ~stop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      txsh_q     <= '0;
      skip_q     <= 1'b0;
      stop_q     <= 1'b1;
      first_q    <= 1'b0;
      cmd_q      <= CMD_NOP;
      din_q      <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rd_q       <= 1'b0;
      hit_q      <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (!ena) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      txsh_q     <= '0;
      skip_q     <= 1'b0;
      stop_q     <= 1'b1;
      first_q    <= 1'b0;
      cmd_q      <= CMD_NOP;
      din_q      <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rd_q       <= 1'b0;
      hit_q      <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_req_q   <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_q     <= bit_stop;
      if (bit_sta) begin
        // A repeated start still owes us the SCL fall that ends it
        state_q <= ADDR;
        cnt_q   <= '0;
        hit_q   <= 1'b0;
        cmd_q   <= CMD_NOP;
        din_q   <= 1'b1;
        skip_q  <= ~bit_stop;
      end else if (stop_edge_d) begin
        state_q <= IDLE;
        cmd_q   <= CMD_NOP;
        din_q   <= 1'b1;
        done_q  <= hit_q;
        hit_q   <= 1'b0;
        skip_q  <= 1'b0;
      end else if (bit_ack) begin
        if (skip_q) begin
          skip_q <= 1'b0;
        end else begin
          unique case (state_q)
            ADDR: begin
              sh_q  <= byte_d[6:0];
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                if (hit_d) begin
                  hit_q   <= 1'b1;
                  rd_q    <= byte_d[0];
                  first_q <= 1'b1;
                  state_q <= ADDR_ACK;
                  cmd_q   <= CMD_WRITE;
                  din_q   <= 1'b0;
                  if (byte_d[0]) begin
                    tx_req_q <= 1'b1;
                    txsh_q   <= tx_data;
                  end
                end else begin
                  state_q <= WAIT_STOP;
                end
              end
            end
            ADDR_ACK: begin
              cnt_q <= '0;
              if (rd_q) begin
                state_q <= TX;
                cmd_q   <= CMD_WRITE;
                din_q   <= txsh_q[7];
              end else begin
                state_q <= RX;
                cmd_q   <= CMD_NOP;
                din_q   <= 1'b1;
              end
            end
            RX: begin
              sh_q  <= byte_d[6:0];
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                rx_data_q  <= byte_d;
                rx_valid_q <= 1'b1;
                rx_first_q <= first_q;
                first_q    <= 1'b0;
                state_q    <= RX_ACK;
                cmd_q      <= CMD_WRITE;
                din_q      <= 1'b0;
              end
            end
            RX_ACK: begin
              state_q <= RX;
              cnt_q   <= '0;
              cmd_q   <= CMD_NOP;
              din_q   <= 1'b1;
            end
            TX: begin
              if (cnt_q != 3'd7) begin
                txsh_q <= {txsh_q[6:0], 1'b0};
                din_q  <= txsh_q[6];
                cnt_q  <= cnt_q + 3'd1;
              end else begin
                state_q <= TX_ACK;
                cmd_q   <= CMD_READ;
                din_q   <= 1'b1;
              end
            end
            TX_ACK: begin
              if (!bit_dout) begin
                tx_req_q <= 1'b1;
                txsh_q   <= tx_data;
                state_q  <= TX;
                cnt_q    <= '0;
                cmd_q    <= CMD_WRITE;
                din_q    <= tx_data[7];
              end else begin
                nack_q  <= 1'b1;
                state_q <= WAIT_STOP;
                cmd_q   <= CMD_NOP;
                din_q   <= 1'b1;
              end
            end
            default: begin
              cmd_q <= CMD_NOP;
              din_q <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bit_cmd   = cmd_q;
  assign bit_din   = din_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_first  = rx_first_q;
  assign tx_req    = tx_req_q;
  assign rd_mode   = rd_q;
  assign addr_hit  = hit_q;
  assign nack_rcvd = nack_q;
  assign xfer_done = done_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench for i2c_slave_byte_ctrl; the bench plays master and
// bit controller, resolving SDA as a wired-AND of both drivers.
module tb_i2c_slave_byte_ctrl;

  logic       clk = 1'b0;
  logic       rst, ena, sel;
  logic [6:0] slave_addr;
  logic       bit_ack, bit_dout, bit_sta, bit_stop;
  logic [7:0] tx_data;

  logic [3:0] cmd_a, cmd_g;
  logic       din_a, din_g;
  logic [7:0] rxd_a, rxd_g;
  logic       rxv_a, rxv_g, rxf_a, rxf_g, txr_a, txr_g;
  logic       rd_a, rd_g, hit_a, hit_g, nk_a, nk_g, dn_a, dn_g;

  logic [3:0] m_cmd;
  logic       m_din, m_rxv, m_rxf, m_txr, m_rd, m_hit, m_nk, m_dn;
  logic [7:0] m_rxd;

  int n_chk = 0;
  int n_bad = 0;
  int n_rx = 0, n_txr = 0, n_nk = 0, n_dn = 0;
  int tx_idx = 0;
  logic [7:0] rx_log [16];
  logic       fst_log [16];
  logic [7:0] tx_tab [8];

  always #5 clk = ~clk;

  i2c_slave_byte_ctrl #(.GENCALL_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .ena(ena), .slave_addr(slave_addr),
    .bit_cmd(cmd_a), .bit_din(din_a), .bit_ack(bit_ack),
    .bit_dout(bit_dout), .bit_sta(bit_sta), .bit_stop(bit_stop),
    .rx_data(rxd_a), .rx_valid(rxv_a), .rx_first(rxf_a),
    .tx_req(txr_a), .tx_data(tx_data), .rd_mode(rd_a),
    .addr_hit(hit_a), .nack_rcvd(nk_a), .xfer_done(dn_a)
  );

  i2c_slave_byte_ctrl #(.GENCALL_EN(1'b1)) dut_gc (
    .clk(clk), .rst(rst), .ena(ena), .slave_addr(slave_addr),
    .bit_cmd(cmd_g), .bit_din(din_g), .bit_ack(bit_ack),
    .bit_dout(bit_dout), .bit_sta(bit_sta), .bit_stop(bit_stop),
    .rx_data(rxd_g), .rx_valid(rxv_g), .rx_first(rxf_g),
    .tx_req(txr_g), .tx_data(tx_data), .rd_mode(rd_g),
    .addr_hit(hit_g), .nack_rcvd(nk_g), .xfer_done(dn_g)
  );

  assign m_cmd = sel ? cmd_g : cmd_a;
  assign m_din = sel ? din_g : din_a;
  assign m_rxd = sel ? rxd_g : rxd_a;
  assign m_rxv = sel ? rxv_g : rxv_a;
  assign m_rxf = sel ? rxf_g : rxf_a;
  assign m_txr = sel ? txr_g : txr_a;
  assign m_rd  = sel ? rd_g  : rd_a;
  assign m_hit = sel ? hit_g : hit_a;
  assign m_nk  = sel ? nk_g  : nk_a;
  assign m_dn  = sel ? dn_g  : dn_a;

  assign tx_data = tx_tab[tx_idx[2:0]];

  always @(negedge clk) begin
    if (m_rxv) begin
      rx_log[n_rx[3:0]]  = m_rxd;
      fst_log[n_rx[3:0]] = m_rxf;
      n_rx++;
    end
    if (m_txr) begin
      n_txr++;
      tx_idx++;
    end
    if (m_nk) n_nk++;
    if (m_dn) n_dn++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bit_cycle(input logic mbit, output logic sda);
    repeat (2) @(negedge clk);
    sda = mbit & ((m_cmd == 4'b0100) ? m_din : 1'b1);
    bit_dout = sda;
    bit_ack  = 1'b1;
    @(negedge clk);
    bit_ack  = 1'b0;
  endtask

  task automatic start(input logic rep);
    logic d;
    @(negedge clk);
    bit_sta = 1'b1;
    @(negedge clk);
    bit_sta  = 1'b0;
    bit_stop = 1'b0;
    if (rep) bit_cycle(1'b1, d);
  endtask

  task automatic stop();
    @(negedge clk);
    bit_stop = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], d);
    bit_cycle(1'b1, ack);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] b,
                       output logic rel);
    logic d;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, d);
      b = {b[6:0], d};
    end
    bit_cycle(~mack, rel);
  endtask

  initial begin
    logic       a, rel;
    logic [7:0] b;
    logic [3:0] nib;
    int s_rx, s_txr, s_nk, s_dn;

    tx_tab[0] = 8'h5A; tx_tab[1] = 8'hC3;
    tx_tab[2] = 8'h77; tx_tab[3] = 8'h96;
    tx_tab[4] = 8'h00; tx_tab[5] = 8'h00;
    tx_tab[6] = 8'h00; tx_tab[7] = 8'h00;
    sel = 1'b0; rst = 1'b1; ena = 1'b1;
    slave_addr = 7'h50;
    bit_ack = 1'b0; bit_dout = 1'b1;
    bit_sta = 1'b0; bit_stop = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd", m_cmd, 4'h0);
    check("rst_din", m_din, 1'b1);
    check("rst_rxd", m_rxd, 8'h00);
    check("rst_hit", m_hit, 1'b0);
    check("rst_rd", m_rd, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: write two bytes to 0x50
    s_rx = n_rx; s_dn = n_dn;
    start(1'b0);
    wbyte(8'hA0, a); check("t1_aack", a, 1'b0);
    check("t1_hit", m_hit, 1'b1);
    check("t1_rd", m_rd, 1'b0);
    wbyte(8'h3C, a); check("t1_ack1", a, 1'b0);
    wbyte(8'h81, a); check("t1_ack2", a, 1'b0);
    stop();
    check("t1_nrx", n_rx - s_rx, 2);
    check("t1_rx0", rx_log[s_rx[3:0]], 8'h3C);
    check("t1_f0", fst_log[s_rx[3:0]], 1'b1);
    check("t1_rx1", rx_log[4'(s_rx + 1)], 8'h81);
    check("t1_f1", fst_log[4'(s_rx + 1)], 1'b0);
    check("t1_done", n_dn - s_dn, 1);
    check("t1_hitclr", m_hit, 1'b0);

    // 2: read two bytes, master ACK then NACK
    s_txr = n_txr; s_nk = n_nk; s_dn = n_dn;
    start(1'b0);
    wbyte(8'hA1, a); check("t2_aack", a, 1'b0);
    check("t2_rd", m_rd, 1'b1);
    rbyte(1'b1, b, rel); check("t2_b0", b, 8'h5A);
    rbyte(1'b0, b, rel); check("t2_b1", b, 8'hC3);
    check("t2_rel", rel, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_cmd", m_cmd, 4'h0);
    check("t2_din", m_din, 1'b1);
    check("t2_txr", n_txr - s_txr, 2);
    check("t2_nack", n_nk - s_nk, 1);
    stop();
    check("t2_done", n_dn - s_dn, 1);

    // 3: foreign address
    s_rx = n_rx; s_dn = n_dn;
    start(1'b0);
    wbyte(8'hA2, a); check("t3_nack", a, 1'b1);
    wbyte(8'h55, a); check("t3_dnack", a, 1'b1);
    check("t3_hit", m_hit, 1'b0);
    stop();
    check("t3_nrx", n_rx - s_rx, 0);
    check("t3_done", n_dn - s_dn, 0);

    // 4: write, repeated start, read one byte
    s_rx = n_rx; s_nk = n_nk; s_dn = n_dn;
    start(1'b0);
    wbyte(8'hA0, a); check("t4_aack", a, 1'b0);
    wbyte(8'h10, a); check("t4_ack", a, 1'b0);
    start(1'b1);
    wbyte(8'hA1, a); check("t4_sack", a, 1'b0);
    check("t4_rd", m_rd, 1'b1);
    rbyte(1'b0, b, rel); check("t4_b", b, 8'h77);
    stop();
    check("t4_nrx", n_rx - s_rx, 1);
    check("t4_rx", rx_log[s_rx[3:0]], 8'h10);
    check("t4_nack", n_nk - s_nk, 1);
    check("t4_done", n_dn - s_dn, 1);

    // 5: general call with and without GENCALL_EN
    sel = 1'b1;
    s_rx = n_rx; s_dn = n_dn;
    start(1'b0);
    wbyte(8'h00, a); check("t5g_aack", a, 1'b0);
    wbyte(8'h06, a); check("t5g_ack", a, 1'b0);
    stop();
    check("t5g_nrx", n_rx - s_rx, 1);
    check("t5g_rx", rx_log[s_rx[3:0]], 8'h06);
    check("t5g_done", n_dn - s_dn, 1);
    sel = 1'b0;
    s_rx = n_rx;
    start(1'b0);
    wbyte(8'h00, a); check("t5n_aack", a, 1'b1);
    wbyte(8'h06, a);
    stop();
    check("t5n_nrx", n_rx - s_rx, 0);

    // 6: reset in the middle of a TX byte
    start(1'b0);
    wbyte(8'hA1, a); check("t6_aack", a, 1'b0);
    nib = '0;
    for (int i = 0; i < 4; i++) begin
      bit_cycle(1'b1, a);
      nib = {nib[2:0], a};
    end
    check("t6_nib", nib, 4'h9);
    check("t6_precmd", m_cmd, 4'h4);
    check("t6_predin", m_din, 1'b0);
    s_rx = n_rx; s_txr = n_txr; s_nk = n_nk; s_dn = n_dn;
    rst = 1'b1; bit_stop = 1'b1;
    #1;
    check("t6_cmd", m_cmd, 4'h0);
    check("t6_din", m_din, 1'b1);
    check("t6_hit", m_hit, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_pulses", (n_rx - s_rx) + (n_txr - s_txr)
                       + (n_nk - s_nk) + (n_dn - s_dn), 0);
    start(1'b0);
    wbyte(8'hA0, a); check("t6_aack2", a, 1'b0);
    check("t6_hit2", m_hit, 1'b1);
    check("t6_rd2", m_rd, 1'b0);
    stop();
    check("t6_done", n_dn - s_dn, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
